evrf_exec: RTL and testbench
============================

Name: evrf_exec

Overview:
- Execution stage directly downstream of the eVRF scheduler: pops eVRF micro-instructions and executes each one.
- Per uOP it either forwards one MVU result vector, reads one vector from the local external VRF, or consumes and discards one MVU result (flush).
- Surviving vectors, each with its tag, go through an output FIFO to the MFU chain.
- The loader fills the local VRF through a dedicated write port.

Parameters:
- ACCW, 32, accumulator element width.
- DOTW, 40, elements per vector; DW = ACCW*DOTW (localparam).
- VRFAW, 9, VRF address width; VRFD = 2**VRFAW.
- NTAGW, 6, tag width.
- UIW, 2+VRFAW+NTAGW, uOP width. Layout: [1:0] src_sel, [VRFAW+1:2] vrf_addr, [UIW-1:VRFAW+2] tag.
- RD_LAT, 2, VRF read latency in cycles (>=1).
- ODEPTH, 8, output FIFO depth (power of 2, >= RD_LAT+2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_uinst_rd_rdy  in  1  scheduler uOP FIFO non-empty.
- i_uinst_rd_dout  in  UIW  head uOP (show-ahead).
- o_uinst_rd_en  out  1  pop uOP.
- i_mvu_valid  in  1  MVU result available.
- i_mvu_data  in  DW  MVU result vector.
- o_mvu_rdy  out  1  consume MVU result.
- i_vrf_wr_en  in  1  VRF write strobe.
- i_vrf_wr_addr  in  VRFAW  VRF write address.
- i_vrf_wr_data  in  DW  VRF write data.
- o_out_valid  out  1  output FIFO non-empty.
- i_out_rdy  in  1  downstream accepts the head.
- o_out_data  out  DW  head vector.
- o_out_tag  out  NTAGW  head tag.
- o_perf_stall_cnt  out  32  see Optional Feature.
- o_perf_flush_cnt  out  32  see Optional Feature.

Behaviour:
- src_sel encoding: 0 = FROM_MVU, 1 = FROM_VRF, 2 = FLUSH_MVU, 3 = NOP.
- Credit tracking: credits = ODEPTH - (FIFO occupancy + in-flight valid entries).
- Issue conditions (combinational; pop happens in the same cycle, at most one uOP per cycle). Requires i_uinst_rd_rdy, plus:
  - FROM_MVU: i_mvu_valid and credits > 0.
  - FROM_VRF: credits > 0.
  - FLUSH_MVU: i_mvu_valid; no credit needed.
  - NOP: always.
- o_mvu_rdy = pop & (src==FROM_MVU | src==FLUSH_MVU). No other MVU consumption.
- Pipeline:
  - Issue stage starts the VRF read and loads a RD_LAT-deep delay line carrying {valid, src, tag, mvu_data}.
  - valid is set only for FROM_MVU and FROM_VRF.
  - At the delay-line tail: data = src==FROM_VRF ? VRF read data : mvu_data. The FIFO is written when valid.
- Latency: pop in cycle t with the FIFO empty gives o_out_valid=1 in cycle t+RD_LAT+1.
- Ordering: output order equals uOP order; no reordering.
- Throughput: one uOP per cycle sustained while credits and inputs allow.
- VRF:
  - Simple dual-port, 1W1R.
  - A read and a write to the same address in the same cycle returns the OLD data.
  - Contents are not reset.
- Output FIFO:
  - Show-ahead; pop when o_out_valid & i_out_rdy.
  - Simultaneous push and pop when full is legal; the credit gate makes overflow impossible.
  - A FIFO pop in the same cycle as an issue does not return its credit until the next cycle (credits are registered).
- Flush: consumes the MVU vector and produces nothing, including when credits are 0.
- Reset, including mid-operation:
  - Clears the delay line, FIFO pointers, credits (=ODEPTH) and perf counters.
  - All outputs read 0 in the cycle after rst is sampled high.
  - In-flight uOPs are lost.
  - o_uinst_rd_en and o_mvu_rdy are 0 while rst is high.

Optional Feature:
- Macro EVRF_EXEC_PERF_EN.
- Defined:
  - o_perf_stall_cnt increments each cycle i_uinst_rd_rdy=1 and no pop occurs.
  - o_perf_flush_cnt increments per FLUSH_MVU executed.
  - Both counters saturate at 2^32-1 and clear on rst.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Forward: VRF write addr 5 = pattern A; uOP {src=1, addr=5, tag=3} with i_out_rdy=1 -> o_out_valid at pop+3, o_out_data=A, o_out_tag=3.
- MVU and flush: 3 MVU vectors M0..M2 queued; uOPs src=0,0,2 tags 7,7,7 -> outputs M0 then M1 only; all 3 MVU vectors consumed; perf_flush_cnt=1 when EVRF_EXEC_PERF_EN is defined.
- Backpressure: i_out_rdy=0; 12 FROM_VRF uOPs -> exactly 8 pops, o_uinst_rd_en then stays 0; release i_out_rdy -> all 12 outputs in address order, none lost or duplicated.
- MVU starvation: FROM_MVU uOP with i_mvu_valid=0 for 10 cycles -> no pop, o_mvu_rdy=0; perf_stall_cnt=10 with EVRF_EXEC_PERF_EN defined, 0 without.
- Collision: same-cycle VRF write addr 9 = B (old value C) and issue of a read of addr 9 -> output C; next read of addr 9 -> B.
- Reset mid-flight: rst for 1 cycle with 2 uOPs in flight and 3 FIFO entries -> o_out_valid=0 next cycle, nothing emitted afterwards, VRF contents intact.

Source files
------------

// File: rtl/evrf_exec.sv
// evrf_exec: eVRF execution stage; forwards MVU results, reads the local VRF or flushes.
// Optional performance counters are built when EVRF_EXEC_PERF_EN is defined.
`timescale 1ns/1ps
module evrf_exec #(
    parameter int ACCW   = 32,
    parameter int DOTW   = 40,
    parameter int VRFAW  = 9,
    parameter int NTAGW  = 6,
    parameter int UIW    = 2 + VRFAW + NTAGW,
    parameter int RD_LAT = 2,
    parameter int ODEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_uinst_rd_rdy,
    input  logic [UIW-1:0]         i_uinst_rd_dout,
    output logic                   o_uinst_rd_en,
    input  logic                   i_mvu_valid,
    input  logic [ACCW*DOTW-1:0]   i_mvu_data,
    output logic                   o_mvu_rdy,
    input  logic                   i_vrf_wr_en,
    input  logic [VRFAW-1:0]       i_vrf_wr_addr,
    input  logic [ACCW*DOTW-1:0]   i_vrf_wr_data,
    output logic                   o_out_valid,
    input  logic                   i_out_rdy,
    output logic [ACCW*DOTW-1:0]   o_out_data,
    output logic [NTAGW-1:0]       o_out_tag,
    output logic [31:0]            o_perf_stall_cnt,
    output logic [31:0]            o_perf_flush_cnt
);

    localparam int DW   = ACCW * DOTW;
    localparam int VRFD = 2 ** VRFAW;
    localparam int OAW  = $clog2(ODEPTH);
    localparam int CW   = OAW + 1;

    localparam logic [1:0] SRC_MVU   = 2'd0;
    localparam logic [1:0] SRC_VRF   = 2'd1;
    localparam logic [1:0] SRC_FLUSH = 2'd2;
    localparam logic [1:0] SRC_NOP   = 2'd3;

    logic [1:0]       w_src;
    logic [VRFAW-1:0] w_addr;
    logic [NTAGW-1:0] w_tag;

    assign w_src  = i_uinst_rd_dout[1:0];
    assign w_addr = i_uinst_rd_dout[VRFAW+1:2];
    assign w_tag  = i_uinst_rd_dout[UIW-1:VRFAW+2];

    logic          r_rst_d;
    logic [CW-1:0] r_credits;
    logic          w_hold;
    logic          w_credit_ok;
    logic          w_src_ok;
    logic          w_pop;
    logic          w_issue_v;
    logic          w_fifo_pop;
    logic          w_push;
    logic          w_empty;
    logic [DW-1:0] w_tail_data;

    // Issue is also held off for the cycle after reset so every output reads 0.
    always_ff @(posedge clk) begin
        r_rst_d <= rst;
    end

    assign w_hold      = rst | r_rst_d;
    assign w_credit_ok = (r_credits != '0);

    always_comb begin
        w_src_ok = 1'b0;
        unique case (w_src)
            SRC_MVU:   w_src_ok = i_mvu_valid & w_credit_ok;
            SRC_VRF:   w_src_ok = w_credit_ok;
            SRC_FLUSH: w_src_ok = i_mvu_valid;
            SRC_NOP:   w_src_ok = 1'b1;
        endcase
    end

    assign w_pop     = i_uinst_rd_rdy & ~w_hold & w_src_ok;
    assign w_issue_v = w_pop & ((w_src == SRC_MVU) | (w_src == SRC_VRF));

    assign o_uinst_rd_en = w_pop;
    assign o_mvu_rdy     = w_pop & ((w_src == SRC_MVU) | (w_src == SRC_FLUSH));

    // Local VRF: read launched every cycle, aligned with the delay line.
    logic [DW-1:0] r_vrf     [VRFD];
    logic [DW-1:0] r_rd_pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (i_vrf_wr_en) begin
            r_vrf[i_vrf_wr_addr] <= i_vrf_wr_data;
        end
        r_rd_pipe[0] <= r_vrf[w_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
        end
    end

    logic             r_dl_v   [RD_LAT];
    logic [1:0]       r_dl_src [RD_LAT];
    logic [NTAGW-1:0] r_dl_tag [RD_LAT];
    logic [DW-1:0]    r_dl_mvu [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_dl_v[i] <= 1'b0;
            end
        end else begin
            r_dl_v[0] <= w_issue_v;
            for (int i = 1; i < RD_LAT; i++) begin
                r_dl_v[i] <= r_dl_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_dl_src[0] <= w_src;
        r_dl_tag[0] <= w_tag;
        r_dl_mvu[0] <= i_mvu_data;
        for (int i = 1; i < RD_LAT; i++) begin
            r_dl_src[i] <= r_dl_src[i-1];
            r_dl_tag[i] <= r_dl_tag[i-1];
            r_dl_mvu[i] <= r_dl_mvu[i-1];
        end
    end

    assign w_push      = r_dl_v[RD_LAT-1];
    assign w_tail_data = (r_dl_src[RD_LAT-1] == SRC_VRF) ?
                         r_rd_pipe[RD_LAT-1] : r_dl_mvu[RD_LAT-1];

    // Output FIFO, show-ahead; the credit gate rules out overflow.
    logic [DW-1:0]    r_fifo_data [ODEPTH];
    logic [NTAGW-1:0] r_fifo_tag  [ODEPTH];
    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_pop = ~w_empty & i_out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr[OAW-1:0]] <= w_tail_data;
            r_fifo_tag[r_wr_ptr[OAW-1:0]]  <= r_dl_tag[RD_LAT-1];
        end
    end

    assign o_out_valid = ~w_empty;
    assign o_out_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr[OAW-1:0]];
    assign o_out_tag   = w_empty ? '0 : r_fifo_tag[r_rd_ptr[OAW-1:0]];

    // A slot freed by a downstream pop becomes usable on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CW'(ODEPTH);
        end else begin
            r_credits <= r_credits - CW'(w_issue_v) + CW'(w_fifo_pop);
        end
    end

`ifdef EVRF_EXEC_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_uinst_rd_rdy & ~w_pop & (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_pop & (w_src == SRC_FLUSH) & (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_stall_cnt = r_stall_cnt;
    assign o_perf_flush_cnt = r_flush_cnt;
`else
    assign o_perf_stall_cnt = '0;
    assign o_perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_evrf_exec.sv
// tb_evrf_exec: randomized scoreboard bench for evrf_exec against a queue-based model.
`timescale 1ns/1ps
module tb_evrf_exec;

    localparam int ACCW   = 32;
    localparam int DOTW   = 40;
    localparam int DW     = ACCW * DOTW;
    localparam int VRFAW  = 9;
    localparam int NTAGW  = 6;
    localparam int UIW    = 2 + VRFAW + NTAGW;
    localparam int RD_LAT = 2;
    localparam int ODEPTH = 8;
`ifdef EVRF_EXEC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             i_uinst_rd_rdy;
    logic [UIW-1:0]   i_uinst_rd_dout;
    logic             o_uinst_rd_en;
    logic             i_mvu_valid;
    logic [DW-1:0]    i_mvu_data;
    logic             o_mvu_rdy;
    logic             i_vrf_wr_en;
    logic [VRFAW-1:0] i_vrf_wr_addr;
    logic [DW-1:0]    i_vrf_wr_data;
    logic             o_out_valid;
    logic             i_out_rdy;
    logic [DW-1:0]    o_out_data;
    logic [NTAGW-1:0] o_out_tag;
    logic [31:0]      o_perf_stall_cnt;
    logic [31:0]      o_perf_flush_cnt;

    always #5 clk = ~clk;

    evrf_exec #(
        .ACCW(ACCW), .DOTW(DOTW), .VRFAW(VRFAW), .NTAGW(NTAGW),
        .UIW(UIW), .RD_LAT(RD_LAT), .ODEPTH(ODEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .i_uinst_rd_rdy(i_uinst_rd_rdy), .i_uinst_rd_dout(i_uinst_rd_dout),
        .o_uinst_rd_en(o_uinst_rd_en),
        .i_mvu_valid(i_mvu_valid), .i_mvu_data(i_mvu_data), .o_mvu_rdy(o_mvu_rdy),
        .i_vrf_wr_en(i_vrf_wr_en), .i_vrf_wr_addr(i_vrf_wr_addr),
        .i_vrf_wr_data(i_vrf_wr_data),
        .o_out_valid(o_out_valid), .i_out_rdy(i_out_rdy),
        .o_out_data(o_out_data), .o_out_tag(o_out_tag),
        .o_perf_stall_cnt(o_perf_stall_cnt), .o_perf_flush_cnt(o_perf_flush_cnt)
    );

    typedef struct { logic [DW-1:0] d; logic [NTAGW-1:0] t; } exp_t;
    typedef struct { logic [1:0] src; logic [VRFAW-1:0] a; logic [NTAGW-1:0] t; } uop_t;

    exp_t          sb[$];
    uop_t          uop_q[$];
    logic [DW-1:0] mvu_q[$];
    int            arr_q[$];
    logic [DW-1:0] vrf_m [2**VRFAW];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int act_pops = 0;
    int act_mvu = 0;
    int out_cnt = 0;
    bit mon_en = 1'b0;

    bit               g_uop, g_mvu, g_out, rst_v, prev_rst;
    bit               wr_en_v;
    logic [VRFAW-1:0] wr_a;
    logic [DW-1:0]    wr_d;
    logic [31:0]      m_stall, m_flush;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        int idx;
        checks++;
        if (act !== exp) begin
            errors++;
            idx = 0;
            for (int i = 0; i < DOTW; i++) begin
                if (act[i*ACCW +: ACCW] !== exp[i*ACCW +: ACCW]) begin
                    idx = i;
                    break;
                end
            end
            $display("FAIL %s: elem %0d got %h expected %h (cycle %0d)", nm, idx,
                     act[idx*ACCW +: ACCW], exp[idx*ACCW +: ACCW], cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DOTW; i++) v[i*ACCW +: ACCW] = $urandom;
        return v;
    endfunction

    function automatic uop_t mk(input int src, input int a, input int t);
        uop_t u;
        u.src = 2'(src);
        u.a   = VRFAW'(a);
        u.t   = NTAGW'(t);
        return u;
    endfunction

    task automatic drive();
        rst = rst_v;
        i_uinst_rd_rdy = g_uop && (uop_q.size() > 0);
        if (uop_q.size() > 0) i_uinst_rd_dout = {uop_q[0].t, uop_q[0].a, uop_q[0].src};
        else i_uinst_rd_dout = '0;
        i_mvu_valid = g_mvu && (mvu_q.size() > 0);
        if (mvu_q.size() > 0) i_mvu_data = mvu_q[0];
        else i_mvu_data = '0;
        i_vrf_wr_en   = wr_en_v;
        i_vrf_wr_addr = wr_a;
        i_vrf_wr_data = wr_d;
        i_out_rdy     = g_out;
    endtask

    // Model: one output slot per issued vector until the consumer takes it.
    task automatic model_eval();
        bit            hold, pop_e, vis, is_mvu;
        int            credits;
        uop_t          u;
        logic [DW-1:0] v;
        hold    = rst_v || prev_rst;
        credits = ODEPTH - arr_q.size();
        pop_e   = 1'b0;
        is_mvu  = 1'b0;
        u       = mk(3, 0, 0);
        if (i_uinst_rd_rdy && !hold) begin
            u = uop_q[0];
            case (u.src)
                2'd0: pop_e = i_mvu_valid && credits > 0;
                2'd1: pop_e = credits > 0;
                2'd2: pop_e = i_mvu_valid;
                default: pop_e = 1'b1;
            endcase
            is_mvu = (u.src == 2'd0) || (u.src == 2'd2);
        end
        vis = (arr_q.size() > 0) && (arr_q[0] + RD_LAT + 1 <= cyc);
        chk("uinst_rd_en", 64'(o_uinst_rd_en), 64'(pop_e));
        chk("mvu_rdy", 64'(o_mvu_rdy), 64'(pop_e && is_mvu));
        chk("out_valid", 64'(o_out_valid), 64'(vis));
        chk("perf_stall", 64'(o_perf_stall_cnt), PERF ? 64'(m_stall) : 64'd0);
        chk("perf_flush", 64'(o_perf_flush_cnt), PERF ? 64'(m_flush) : 64'd0);
        if (prev_rst && !rst_v) begin
            chk_vec("post_rst_data", o_out_data, '0);
            chk("post_rst_tag", 64'(o_out_tag), 64'd0);
        end
        if (o_uinst_rd_en) act_pops++;
        if (o_mvu_rdy) act_mvu++;
        if (pop_e) begin
            void'(uop_q.pop_front());
            case (u.src)
                2'd0: begin
                    v = mvu_q.pop_front();
                    sb.push_back('{d: v, t: u.t});
                    arr_q.push_back(cyc);
                end
                2'd1: begin
                    sb.push_back('{d: vrf_m[u.a], t: u.t});
                    arr_q.push_back(cyc);
                end
                2'd2: begin
                    void'(mvu_q.pop_front());
                    if (m_flush != 32'hffff_ffff) m_flush++;
                end
                default: ;
            endcase
        end
        if (i_uinst_rd_rdy && !pop_e && m_stall != 32'hffff_ffff) m_stall++;
        if (wr_en_v) vrf_m[wr_a] = wr_d;
        if (vis && g_out) void'(arr_q.pop_front());
        if (rst_v) begin
            arr_q.delete();
            sb.delete();
            m_stall = '0;
            m_flush = '0;
        end
        prev_rst = rst_v;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        wr_en_v = 1'b0;
        rst_v   = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en_v = 1'b1;
        wr_a    = VRFAW'(a);
        wr_d    = d;
        cycle();
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        g_uop = 1'b1;
        g_mvu = 1'b1;
        g_out = 1'b1;
        while ((uop_q.size() > 0 || arr_q.size() > 0) && n < 300) begin
            cycle();
            n++;
        end
        chk({nm, "_timeout"}, 64'(n < 300), 64'd1);
        chk({nm, "_sb_left"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compares every accepted output against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && o_out_valid && i_out_rdy) begin
            out_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got tag %0h, expected no output (cycle %0d)",
                         o_out_tag, cyc);
            end else begin
                e = sb.pop_front();
                chk_vec("out_data", o_out_data, e.d);
                chk("out_tag", 64'(o_out_tag), 64'(e.t));
            end
        end
    end

    initial begin
        int o0, a0, p0, need;
        logic [DW-1:0] va, vb, vc;
        g_uop = 0; g_mvu = 0; g_out = 0;
        wr_en_v = 0; wr_a = '0; wr_d = '0;
        rst_v = 1; prev_rst = 1;
        m_stall = '0; m_flush = '0;
        drive();
        @(posedge clk);
        #1;
        rst_v = 1;
        cycle();
        mon_en = 1;
        cycle();

        for (int a = 0; a < 32; a++) wr(a, rand_vec());

        // forward from VRF
        va = rand_vec();
        wr(5, va);
        o0 = out_cnt;
        uop_q.push_back(mk(1, 5, 3));
        drain("fwd");
        chk("fwd_outs", 64'(out_cnt - o0), 64'd1);

        // two forwards then a flush
        for (int i = 0; i < 3; i++) mvu_q.push_back(rand_vec());
        uop_q.push_back(mk(0, 0, 7));
        uop_q.push_back(mk(0, 0, 7));
        uop_q.push_back(mk(2, 0, 7));
        o0 = out_cnt;
        a0 = act_mvu;
        drain("mvu");
        chk("mvu_outs", 64'(out_cnt - o0), 64'd2);
        chk("mvu_consumed", 64'(act_mvu - a0), 64'd3);
        chk("mvu_flush_cnt", 64'(o_perf_flush_cnt), PERF ? 64'd1 : 64'd0);

        // read/write collision on address 9
        vc = rand_vec();
        vb = rand_vec();
        wr(9, vc);
        uop_q.push_back(mk(1, 9, 1));
        uop_q.push_back(mk(1, 9, 2));
        wr_en_v = 1;
        wr_a = 9;
        wr_d = vb;
        cycle();
        drain("coll");

        // backpressure: only ODEPTH issues fit
        g_out = 0;
        for (int i = 0; i < 12; i++) uop_q.push_back(mk(1, 16 + i, i));
        p0 = act_pops;
        repeat (20) cycle();
        chk("bp_pops", 64'(act_pops - p0), 64'd8);
        o0 = out_cnt;
        drain("bp");
        chk("bp_outs", 64'(out_cnt - o0), 64'd12);

        // reset with 3 queued and 2 in flight
        g_out = 0;
        for (int i = 0; i < 5; i++) uop_q.push_back(mk(1, i, 40 + i));
        repeat (5) cycle();
        g_uop = 0;
        rst_v = 1;
        cycle();
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        g_out = 1;
        o0 = out_cnt;
        repeat (10) cycle();
        chk("rst_no_emit", 64'(out_cnt - o0), 64'd0);
        for (int i = 0; i < 5; i++) uop_q.push_back(mk(1, i, 50 + i));
        o0 = out_cnt;
        drain("rst_vrf");
        chk("rst_vrf_outs", 64'(out_cnt - o0), 64'd5);

        // MVU starvation
        g_uop = 0;
        rst_v = 1;
        cycle();
        cycle();
        uop_q.push_back(mk(0, 0, 12));
        g_uop = 1;
        g_mvu = 0;
        a0 = act_mvu;
        repeat (10) cycle();
        chk("starve_stall", 64'(o_perf_stall_cnt), PERF ? 64'd10 : 64'd0);
        chk("starve_mvu_rdy", 64'(act_mvu - a0), 64'd0);
        mvu_q.push_back(rand_vec());
        drain("starve");

        // randomized traffic
        repeat (600) begin
            if ($urandom_range(2) == 0 && uop_q.size() < 6)
                uop_q.push_back(mk($urandom_range(3), $urandom_range(31), $urandom_range(63)));
            if ($urandom_range(2) == 0 && mvu_q.size() < 6) mvu_q.push_back(rand_vec());
            g_uop = ($urandom_range(4) != 0);
            g_mvu = ($urandom_range(9) < 7);
            g_out = ($urandom_range(9) < 6);
            if ($urandom_range(4) == 0) begin
                wr_en_v = 1;
                wr_a = VRFAW'($urandom_range(31));
                wr_d = rand_vec();
            end
            cycle();
        end
        need = 0;
        foreach (uop_q[i]) if (uop_q[i].src == 2'd0 || uop_q[i].src == 2'd2) need++;
        while (mvu_q.size() < need) mvu_q.push_back(rand_vec());
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
